// File: rtl/regwrite_arb.sv
// regwrite_arb: shares the single register-file write port between the
// in-order pipeline writeback and a long-latency unit. Long-latency results
// are buffered in a small FIFO and retired in idle writeback slots; a
// starvation counter forces a one-cycle pipeline stall so buffered results
// always drain.
//
// Handshake (long-latency side): a result transfers on a rising clk edge
// when lu_valid_i && lu_ready_o are both high in that cycle; lu_ready_o does
// not depend on lu_valid_i, and a result addressed to x0 is accepted but
// dropped.
module regwrite_arb #(
  parameter int XLEN         = 32,
  parameter int RAW          = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we_i,
  input  logic [RAW-1:0]           pipe_waddr_i,
  input  logic [XLEN-1:0]          pipe_wdata_i,
  input  logic                     lu_valid_i,
  output logic                     lu_ready_o,
  input  logic [RAW-1:0]           lu_waddr_i,
  input  logic [XLEN-1:0]          lu_wdata_i,
  output logic                     pipe_stall_o,
  output logic                     rf_we_o,
  output logic [RAW-1:0]           rf_waddr_o,
  output logic [XLEN-1:0]          rf_wdata_o,
  input  logic [RAW-1:0]           hz_raddr_i,
  output logic                     hz_hit_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and pointers
  logic [RAW-1:0]  mem_addr_q [DEPTH];
  logic [RAW-1:0]  mem_addr_d [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic [XLEN-1:0] mem_data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;

  // Registered write port
  logic            rf_we_q, rf_we_d;
  logic [RAW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic pipe_wr;
  logic [PW-1:0] hz_off;
  logic          hz_any;

  // Grant decision: forced stall drains the head, otherwise the pipeline
  // wins, otherwise an idle slot drains the head.
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == CW'(DEPTH));
    lu_ready_o   = !rst && !fifo_full;
    pipe_stall_o = !rst && !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    push         = lu_valid_i && lu_ready_o && (lu_waddr_i != '0);
    pop          = !rst && !fifo_empty && (pipe_stall_o || !pipe_we_i);
    pipe_wr      = !rst && !pipe_stall_o && pipe_we_i && (pipe_waddr_i != '0);
  end

  // FIFO next state: storage, pointers, occupancy and starvation counter
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_addr_d[i] = mem_addr_q[i];
      mem_data_d[i] = mem_data_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (push) begin
      mem_addr_d[wr_ptr_q] = lu_waddr_i;
      mem_data_d[wr_ptr_q] = lu_wdata_i;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    // A waiting head that is not retired this cycle ages by one
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Write-port next state: the granted source is presented one cycle later
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_addr_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end else if (pipe_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr_i;
      rf_wdata_d = pipe_wdata_i;
    end
  end

  // Hazard lookup over occupied entries (head included, incoming excluded)
  always_comb begin
    hz_any = 1'b0;
    hz_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_off = PW'(i) - rd_ptr_q;
      if (({1'b0, hz_off} < count_q) && (mem_addr_q[i] == hz_raddr_i)) begin
        hz_any = 1'b1;
      end
    end
    hz_hit_o = !rst && hz_any && (hz_raddr_i != '0);
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_addr_q[i] <= mem_addr_d[i];
      mem_data_q[i] <= mem_data_d[i];
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pend_cnt_o = count_q;

endmodule

// File: tb/tb_regwrite_arb.sv
// Testbench for regwrite_arb: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based
// behavioural model of the arbiter.
module tb_regwrite_arb;

  localparam int XLEN         = 32;
  localparam int RAW          = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            pipe_we_i;
  logic [RAW-1:0]  pipe_waddr_i;
  logic [XLEN-1:0] pipe_wdata_i;
  logic            lu_valid_i;
  logic            lu_ready_o;
  logic [RAW-1:0]  lu_waddr_i;
  logic [XLEN-1:0] lu_wdata_i;
  logic            pipe_stall_o;
  logic            rf_we_o;
  logic [RAW-1:0]  rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic [RAW-1:0]  hz_raddr_i;
  logic            hz_hit_o;
  logic [CW-1:0]   pend_cnt_o;

  regwrite_arb #(
    .XLEN(XLEN), .RAW(RAW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
    .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
    .pipe_stall_o(pipe_stall_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .hz_raddr_i(hz_raddr_i), .hz_hit_o(hz_hit_o),
    .pend_cnt_o(pend_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Buffered results, oldest first: {waddr, wdata}
  logic [RAW+XLEN-1:0] exp_q[$];
  int                  m_starve = 0;
  logic                e_we     = 1'b0;
  logic [RAW-1:0]      e_addr   = '0;
  logic [XLEN-1:0]     e_data   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cycle, act, exp);
    end
  endtask

  // ---------------- driver + model + compare ----------------
  // One cycle: drive inputs after negedge, compare all outputs against the
  // model, then advance the model to what the next clock edge must produce.
  task automatic step(input logic r, input logic pwe, input logic [RAW-1:0] pa,
                      input logic [XLEN-1:0] pd, input logic lv,
                      input logic [RAW-1:0] la, input logic [XLEN-1:0] ld,
                      input logic [RAW-1:0] hr);
    logic m_ready, m_stall, m_hit, m_pop, m_push;
    int   n;
    @(negedge clk);
    rst = r; pipe_we_i = pwe; pipe_waddr_i = pa; pipe_wdata_i = pd;
    lu_valid_i = lv; lu_waddr_i = la; lu_wdata_i = ld; hz_raddr_i = hr;
    #1;
    n       = exp_q.size();
    m_ready = !r && (n < DEPTH);
    m_stall = !r && (n > 0) && (m_starve == STARVE_LIMIT);
    m_hit   = 1'b0;
    if (!r && hr != 0)
      foreach (exp_q[i]) if (exp_q[i][RAW+XLEN-1:XLEN] == hr) m_hit = 1'b1;

    chk("lu_ready", lu_ready_o, m_ready);
    chk("pipe_stall", pipe_stall_o, m_stall);
    chk("hz_hit", hz_hit_o, m_hit);
    chk("pend_cnt", pend_cnt_o, n);
    chk("rf_we", rf_we_o, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr_o, e_addr);
      chk("rf_wdata", rf_wdata_o, e_data);
    end

    if (r) begin
      exp_q.delete();
      m_starve = 0;
      e_we = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      m_pop  = (n > 0) && (m_stall || !pwe);
      m_push = m_ready && lv && (la != 0);
      if (m_pop) begin
        e_we   = 1'b1;
        e_addr = exp_q[0][RAW+XLEN-1:XLEN];
        e_data = exp_q[0][XLEN-1:0];
        void'(exp_q.pop_front());
      end else if (pwe && pa != 0) begin
        e_we = 1'b1; e_addr = pa; e_data = pd;
      end else begin
        e_we = 1'b0;
      end
      if (n == 0 || m_pop) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (m_push) exp_q.push_back({la, ld});
    end
    cycle++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    rst = 1'b1; pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
    lu_valid_i = 0; lu_waddr_i = 0; lu_wdata_i = 0; hz_raddr_i = 0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_rf_waddr", rf_waddr_o, 0);
    chk("rst_rf_wdata", rf_wdata_o, 0);
    chk("rst_pend", pend_cnt_o, 0);
    chk("rst_lu_ready", lu_ready_o, 0);
    idle(2);

    // Idle pipeline, single LU result: written two cycles after the push
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d1_pend_one", pend_cnt_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d1_we", rf_we_o, 1);
    chk("d1_addr", rf_waddr_o, 5);
    chk("d1_data", rf_wdata_o, 32'hDEADBEEF);
    chk("d1_pend_zero", pend_cnt_o, 0);
    idle(2);

    // Saturated pipeline: forced stall retires the LU result
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 3, 32'h300 + k, k == 0, 7, 32'h77, 0);
      if (k >= 2 && k <= 5) chk("d2_pipe_addr", rf_waddr_o, 3);
      if (k == 4) chk("d2_no_stall_yet", pipe_stall_o, 0);
      if (k == 5) chk("d2_stall", pipe_stall_o, 1);
      if (k == 6) begin
        chk("d2_stall_drop", pipe_stall_o, 0);
        chk("d2_lu_we", rf_we_o, 1);
        chk("d2_lu_addr", rf_waddr_o, 7);
        chk("d2_lu_data", rf_wdata_o, 32'h77);
      end
      if (k == 7) begin
        chk("d2_resume_addr", rf_waddr_o, 3);
        chk("d2_resume_data", rf_wdata_o, 32'h306);
      end
    end
    idle(3);

    // Fill the FIFO under a saturated pipeline
    step(0, 1, 1, 32'h10, 1, 10, 32'hA0, 0);
    step(0, 1, 1, 32'h11, 1, 11, 32'hB0, 0);
    chk("d3_ready_one", lu_ready_o, 1);
    step(0, 1, 1, 32'h12, 1, 12, 32'hC0, 0);
    chk("d3_full_ready", lu_ready_o, 0);
    chk("d3_full_pend", pend_cnt_o, 2);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step(0, 1, 1, 32'h13, 0, 0, 0, 0);
      if (pipe_stall_o === 1'b1) seen = 1'b1;
    end
    chk("d3_stall_seen", seen, 1);
    step(0, 1, 1, 32'h14, 0, 0, 0, 0);
    chk("d3_ready_back", lu_ready_o, 1);
    chk("d3_pend_after_pop", pend_cnt_o, 1);
    idle(3);

    // x0 destinations never produce a write
    step(0, 1, 0, 32'h55, 1, 0, 32'h66, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d4_pend", pend_cnt_o, 0);
    chk("d4_we_a", rf_we_o, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d4_we_b", rf_we_o, 0);
    idle(1);

    // Hazard lookup
    step(0, 1, 2, 32'h20, 1, 9, 32'h99, 9);
    chk("d5_hit_push", hz_hit_o, 0);
    step(0, 1, 2, 32'h21, 0, 0, 0, 9);
    chk("d5_hit", hz_hit_o, 1);
    step(0, 1, 2, 32'h22, 0, 0, 0, 0);
    chk("d5_hit_x0", hz_hit_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step(0, 1, 2, 32'h23, 0, 0, 0, 9);
      if (pipe_stall_o === 1'b1) begin
        seen = 1'b1;
        chk("d5_hit_pop", hz_hit_o, 1);
      end
    end
    chk("d5_stall_seen", seen, 1);
    step(0, 1, 2, 32'h24, 0, 0, 0, 9);
    chk("d5_hit_gone", hz_hit_o, 0);
    idle(2);

    // Reset with two entries buffered
    step(0, 1, 4, 32'h40, 1, 20, 32'h200, 0);
    step(0, 1, 4, 32'h41, 1, 21, 32'h210, 0);
    step(1, 1, 4, 32'h42, 1, 22, 32'h220, 0);
    chk("d6_rst_ready", lu_ready_o, 0);
    chk("d6_rst_pend_before", pend_cnt_o, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d6_no_write", rf_we_o, 0);
    chk("d6_pend_zero", pend_cnt_o, 0);
    chk("d6_ready_back", lu_ready_o, 1);
    idle(2);

    // Randomized traffic, pipeline load varies per phase
    for (int ph = 0; ph < 6; ph++) begin
      int load;
      load = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 70 : 95);
      for (int k = 0; k < 500; k++) begin
        step($urandom_range(0, 149) == 0,
             $urandom_range(0, 99) < load,
             RAW'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 99) < 50,
             RAW'($urandom_range(0, 7)), $urandom,
             RAW'($urandom_range(0, 7)));
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_arb.md
# regwrite_arb

Register-file write-port arbiter placed between the writeback stage and the register file. It shares the single write port between the in-order pipeline writeback and a long-latency unit (multiplier/divider) whose results arrive asynchronously to the pipeline. Long-latency results are buffered in a small FIFO and drained in idle writeback slots. A starvation counter forces a one-cycle pipeline stall so that buffered results always retire.

## Interface
- XLEN, 32, data width
- RAW, 5, register address width
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive denied cycles before a forced stall (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_we_i  in  1  pipeline writeback write-enable
- pipe_waddr_i  in  RAW  pipeline destination register
- pipe_wdata_i  in  XLEN  pipeline writeback data (already muxed mem/ALU)
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  FIFO can accept a result
- lu_waddr_i  in  RAW  long-latency destination register
- lu_wdata_i  in  XLEN  long-latency result data
- pipe_stall_o  out  1  pipeline must hold its writeback this cycle
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  RAW  register-file write address (registered)
- rf_wdata_o  out  XLEN  register-file write data (registered)
- hz_raddr_i  in  RAW  register being read by decode
- hz_hit_o  out  1  hz_raddr_i has a pending buffered write
- pend_cnt_o  out  clog2(DEPTH)+1  number of buffered entries

## Operation
- FIFO: push when lu_valid_i && lu_ready_o && lu_waddr_i != 0. x0 results are accepted and discarded.
- lu_ready_o = !rst && (count < DEPTH). A push never occurs when full, even if a pop occurs in the same cycle.
- Grant, evaluated every cycle:
  - If pipe_stall_o = 1: FIFO head granted. Pipeline re-presents the same writeback next cycle; pipe_we_i is ignored this cycle.
  - Else if pipe_we_i = 1: pipeline granted; write issued only if pipe_waddr_i != 0.
  - Else if FIFO non-empty: head granted (pop).
  - Else: no write.
- Starvation counter starve_cnt:
  - Increments when FIFO is non-empty and no pop occurs.
  - Clears on any pop or when FIFO is empty.
  - Saturates at STARVE_LIMIT.
- pipe_stall_o = !rst && (starve_cnt == STARVE_LIMIT) && FIFO non-empty. Combinational, held for exactly one cycle per starvation event.
- Push and pop in the same cycle are legal when not full; count is unchanged.
- hz_hit_o = 1 if any valid FIFO entry has waddr == hz_raddr_i and hz_raddr_i != 0. Combinational, includes the entry being popped this cycle. Does not include the entry being pushed this cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Reset values: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, FIFO empty, starve_cnt = 0, pend_cnt_o = 0, hz_hit_o = 0, pipe_stall_o = 0, lu_ready_o = 0 while rst is high.
- Reset mid-operation: buffered entries are lost and no write is issued in the cycle after rst.
- Grant at cycle N → rf_we_o/rf_waddr_o/rf_wdata_o valid in cycle N+1, held for one cycle.
- No FIFO bypass: a push at cycle N is poppable at N+1 at the earliest, so rf_we_o rises at N+2 at the earliest.
- Worst-case retirement of the FIFO head under continuous pipe_we_i: granted STARVE_LIMIT+1 cycles after it becomes head.
- pend_cnt_o reflects registered count (post-edge).

## Test plan
- Idle pipeline, lu_valid_i pulse with addr 5, data 0xDEADBEEF at cycle 10 → rf_we_o = 1, addr 5, data 0xDEADBEEF at cycle 12; pend_cnt_o returns to 0.
- pipe_we_i held high with addr 3, plus one LU push (addr 7) at cycle 0 → pipeline wins cycles 1–4; pipe_stall_o = 1 at cycle 5; rf write to addr 7 at cycle 6; pipeline writes resume at cycle 7.
- With the pipeline saturated, fill DEPTH = 2 entries → lu_ready_o = 0 and pend_cnt_o = 2; a further lu_valid_i is not pushed; lu_ready_o returns to 1 the cycle after the first pop.
- LU push to x0 and pipe_we_i to x0 → no rf_we_o pulse, pend_cnt_o stays 0.
- Buffered entry for addr 9, hz_raddr_i = 9 → hz_hit_o = 1; hz_raddr_i = 0 → hz_hit_o = 0; after the pop cycle → hz_hit_o = 0.
- rst asserted with 2 entries buffered → next cycle rf_we_o = 0, pend_cnt_o = 0, lu_ready_o = 0 during rst and 1 after release.
